// File: rtl/safas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safas_pkg
// Description : Shared definitions for the SAFAS task dispatcher: task word
//               field layout, dispatcher state encoding and field helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package safas_pkg;

    // Task word layout (queue word is c_TASK_W bits, i.e. queue W-1):
    //   [40:33] id | [32:17] deadline | [16:1] exec | [0] flag (ignored)
    localparam int c_ID_W   = 8;
    localparam int c_TIME_W = 16;
    localparam int c_TASK_W = c_ID_W + 2 * c_TIME_W + 1;
    localparam int c_ID_LSB = c_TASK_W - c_ID_W;
    localparam int c_DL_LSB = c_ID_LSB - c_TIME_W;
    localparam int c_EX_LSB = 1;

    // Dispatcher state encoding
    localparam int                c_ST_W     = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_FETCH = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_RUN   = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_MISS  = 3'd4;

    function automatic logic [c_ID_W-1:0] get_id(input logic [c_TASK_W-1:0] word);
        return word[c_ID_LSB +: c_ID_W];
    endfunction

    function automatic logic [c_TIME_W-1:0] get_deadline(input logic [c_TASK_W-1:0] word);
        return word[c_DL_LSB +: c_TIME_W];
    endfunction

    function automatic logic [c_TIME_W-1:0] get_exec(input logic [c_TASK_W-1:0] word);
        return word[c_EX_LSB +: c_TIME_W];
    endfunction

    // Time fields never wrap below zero
    function automatic logic [c_TIME_W-1:0] sat_dec(input logic [c_TIME_W-1:0] val);
        return (val == '0) ? val : val - 1'b1;
    endfunction

endpackage : safas_pkg
`default_nettype wire

// File: rtl/task_dispatcher_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Scheduler time base. Divides clk into time units, emits a
//               one-cycle subtract pulse per unit followed by a repair window,
//               and flags when the queue must not be popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV   = 16,
    parameter int REPAIR_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_subtract,
    output logic o_repair,
    output logic o_pop_block
);

    localparam int                 c_CNT_W    = $clog2(TICK_DIV);
    localparam int                 c_REP_W    = $clog2(REPAIR_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_REP_W-1:0] c_REP_LOAD = c_REP_W'(REPAIR_CYC);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_REP_W-1:0] r_rep;
    logic               w_tick;

    // A frozen counter parked on its last value must not keep firing
    assign w_tick = i_en && (r_cnt == c_CNT_MAX);

    // Time-unit counter, wraps at TICK_DIV-1, frozen while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    // Repair window: loaded on the subtract pulse, counts down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep <= '0;
        end else if (w_tick) begin
            r_rep <= c_REP_LOAD;
        end else if (r_rep != '0) begin
            r_rep <= r_rep - 1'b1;
        end
    end

    assign o_subtract  = w_tick;
    assign o_repair    = (r_rep != '0);
    assign o_pop_block = o_subtract | o_repair;

endmodule : tick_gen
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : task_dispatcher
// Description : Read side of the SAFAS insertion queue. Pops the earliest-
//               deadline task, runs it for its execution time against its
//               deadline, reports done/miss, drives the queue time base and
//               counts tasks the queue drops on its own.
// Revision    : 1.0 - initial release
// ============================================================================
module task_dispatcher
    import safas_pkg::*;
#(
    parameter int W          = 42,
    parameter int TICK_DIV   = 16,
    parameter int REPAIR_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         q_empty,
    input  logic [W-2:0] q_data,
    input  logic         q_fail,
    input  logic [W-2:0] q_fail_data,
    output logic         q_rd,
    output logic         q_subtract,
    output logic         q_repair,
    output logic         busy,
    output logic [7:0]   run_id,
    output logic         done,
    output logic [7:0]   done_id,
    output logic         miss,
    output logic [7:0]   miss_id,
    output logic [15:0]  fail_cnt
);

    localparam logic [15:0] c_FAIL_MAX = 16'hFFFF;

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_nxt;
    logic [c_ID_W-1:0]   r_id;
    logic [c_ID_W-1:0]   w_id_nxt;
    logic [c_TIME_W-1:0] r_dl;
    logic [c_TIME_W-1:0] w_dl_nxt;
    logic [c_TIME_W-1:0] r_ex;
    logic [c_TIME_W-1:0] w_ex_nxt;
    logic [15:0]         r_fail_cnt;

    logic                w_tick;
    logic                w_pop_block;
    logic                w_rd;
    logic                w_busy;
    logic [c_ID_W-1:0]   w_run_id;
    logic                w_done;
    logic                w_miss;

    logic [c_TIME_W-1:0] w_fetch_dl;
    logic [c_TIME_W-1:0] w_fetch_ex;
    logic [c_TIME_W-1:0] w_run_dl;
    logic [c_TIME_W-1:0] w_run_ex;
    logic                w_unused_fail_data;

    tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .REPAIR_CYC (REPAIR_CYC)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .o_subtract  (w_tick),
        .o_repair    (q_repair),
        .o_pop_block (w_pop_block)
    );

    // Fetched times already account for a tick landing in the FETCH cycle
    assign w_fetch_dl = w_tick ? sat_dec(get_deadline(q_data)) : get_deadline(q_data);
    assign w_fetch_ex = w_tick ? sat_dec(get_exec(q_data))     : get_exec(q_data);
    assign w_run_dl   = sat_dec(r_dl);
    assign w_run_ex   = sat_dec(r_ex);

    // The failed task's contents are not needed, only the event itself
    assign w_unused_fail_data = &{1'b0, q_fail_data};

    // Dispatcher next-state and outputs; exec reaching zero beats a deadline tie
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_dl_nxt    = r_dl;
        w_ex_nxt    = r_ex;
        w_rd        = 1'b0;
        w_busy      = 1'b0;
        w_run_id    = '0;
        w_done      = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!q_empty && !w_pop_block) begin
                    w_rd        = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_busy   = 1'b1;
                w_run_id = get_id(q_data);
                w_id_nxt = get_id(q_data);
                w_dl_nxt = w_fetch_dl;
                w_ex_nxt = w_fetch_ex;
                if (w_fetch_ex == '0) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_fetch_dl == '0) begin
                    w_state_nxt = c_ST_MISS;
                end else begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_busy   = 1'b1;
                w_run_id = r_id;
                if (w_tick) begin
                    w_dl_nxt = w_run_dl;
                    w_ex_nxt = w_run_ex;
                    if (w_run_ex == '0) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (w_run_dl == '0) begin
                        w_state_nxt = c_ST_MISS;
                    end
                end
            end
            c_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_MISS: begin
                w_miss      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and latched task; reset drops any in-flight task silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_id    <= '0;
            r_dl    <= '0;
            r_ex    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            r_dl    <= w_dl_nxt;
            r_ex    <= w_ex_nxt;
        end
    end

    // Saturating count of tasks the queue dropped itself
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= '0;
        end else if (q_fail && (r_fail_cnt != c_FAIL_MAX)) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    assign q_rd       = w_rd;
    assign q_subtract = w_tick;
    assign busy       = w_busy;
    assign run_id     = w_run_id;
    assign done       = w_done;
    assign done_id    = w_done ? r_id : '0;
    assign miss       = w_miss;
    assign miss_id    = w_miss ? r_id : '0;
    assign fail_cnt   = r_fail_cnt;

endmodule : task_dispatcher
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_dispatcher
// Description : Self-checking bench for task_dispatcher. The bench plays the
//               queue, keeps a time-base model and a scoreboard of expected
//               done/miss results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task_dispatcher;

    localparam int W = 42;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         q_empty = 1'b1;
    logic [W-2:0] q_data = '0;
    logic         q_fail = 1'b0;
    logic [W-2:0] q_fail_data = '0;
    logic         q_rd;
    logic         q_subtract;
    logic         q_repair;
    logic         busy;
    logic [7:0]   run_id;
    logic         done;
    logic [7:0]   done_id;
    logic         miss;
    logic [7:0]   miss_id;
    logic [15:0]  fail_cnt;

    task_dispatcher #(.W(W), .TICK_DIV(16), .REPAIR_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .q_empty     (q_empty),
        .q_data      (q_data),
        .q_fail      (q_fail),
        .q_fail_data (q_fail_data),
        .q_rd        (q_rd),
        .q_subtract  (q_subtract),
        .q_repair    (q_repair),
        .busy        (busy),
        .run_id      (run_id),
        .done        (done),
        .done_id     (done_id),
        .miss        (miss),
        .miss_id     (miss_id),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         is_done;
        logic [7:0] id;
    } sb_t;

    sb_t          sb[$];
    logic [W-2:0] tb_q[$];
    bit           mon_on = 1'b0;
    int           rd_cnt = 0;
    int           done_cnt = 0;
    int           evt_cnt = 0;
    int           n_pops = 0;
    int           m_cnt = 0;
    int           m_rep = 0;

    // Time-base reference: 16-cycle unit, 4-cycle repair window after each pulse
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            m_rep = 0;
        end else begin
            if (en && m_cnt == 15) m_rep = 4;
            else if (m_rep != 0)   m_rep = m_rep - 1;
            if (en) m_cnt = (m_cnt == 15) ? 0 : m_cnt + 1;
        end
    end

    // Queue model: pop the head when q_rd is seen, present it during FETCH
    initial begin : feeder
        bit rd_seen;
        forever begin
            @(negedge clk);
            rd_seen = (q_rd === 1'b1);
            @(posedge clk);
            #2;
            if (rd_seen && tb_q.size() > 0) q_data = tb_q.pop_front();
            q_empty = (tb_q.size() == 0);
        end
    end

    // Per-cycle time-base checks and scoreboard of done/miss results
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("tick_sub", q_subtract, (en && m_cnt == 15));
                check("tick_rep", q_repair, (m_rep != 0));
                check("rd_guard", q_rd & (q_subtract | q_repair), 0);
                if (q_rd) rd_cnt++;
                if (done) done_cnt++;
                if (done || miss) begin
                    evt_cnt++;
                    if (sb.size() == 0) begin
                        check("sb_unexpected", {done, miss}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_kind", {done, miss}, e.is_done ? 2 : 1);
                        check("sb_id", done ? done_id : miss_id, e.id);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic align(input int phase);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (m_cnt == phase) break;
        end
    endtask

    // Offer one task to the queue at a negedge and follow it to its result
    task automatic run_task(input logic [7:0] id, input logic [15:0] dl, input logic [15:0] ex,
                            output int rd_phase, output bit fetch_tick);
        sb_t it;
        int  n;
        int  t;
        int  k;
        it.is_done = (ex <= dl);
        it.id      = id;
        n          = it.is_done ? int'(ex) : int'(dl);
        tb_q.push_back({id, dl, ex, 1'b0});
        sb.push_back(it);
        n_pops++;
        rd_phase   = -1;
        fetch_tick = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!q_rd && k < 100);
        if (!q_rd) begin
            check("rd_timeout", 0, 1);
            return;
        end
        rd_phase = m_cnt;
        @(negedge clk);
        check("fetch_busy", busy, 1);
        check("fetch_run_id", run_id, id);
        fetch_tick = q_subtract;
        t = 0;
        k = 0;
        forever begin
            if (q_subtract) t++;
            if (t >= n || k > 300) break;
            @(negedge clk);
            k++;
            if (t < n) check("run_busy", busy, 1);
        end
        @(negedge clk);
        check("evt_kind", {done, miss}, it.is_done ? 2 : 1);
        check("evt_id", it.is_done ? done_id : miss_id, id);
    endtask

    initial begin : stim
        int ph;
        bit ft;
        int r0;
        int d0;
        int k;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("rst_outs", {q_rd, q_subtract, q_repair, busy, done, miss}, 0);
        check("rst_ids", {run_id, done_id, miss_id}, 0);
        check("rst_fail_cnt", fail_cnt, 0);

        // Empty queue: time base only, never a pop
        repeat (48) @(negedge clk);
        check("t1_no_rd", rd_cnt, 0);

        // Time base frozen while disabled
        @(posedge clk); #1 en = 1'b0;
        repeat (24) @(negedge clk);
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);

        // Task completes in time
        r0 = rd_cnt;
        run_task(8'h01, 16'd6, 16'd4, ph, ft);
        check("t2_rd_once", rd_cnt - r0, 1);

        // Deadline expires first
        d0 = done_cnt;
        run_task(8'h02, 16'd3, 16'd5, ph, ft);
        check("t3_no_done", done_cnt - d0, 0);

        // Exec and deadline hit zero together: exec wins
        run_task(8'h0A, 16'd3, 16'd3, ph, ft);

        // Pop attempted on a subtract cycle waits out the repair window
        align(14);
        run_task(8'h03, 16'd5, 16'd2, ph, ft);
        check("t4_rd_phase", ph, 4);

        // Zero execution time
        run_task(8'h07, 16'd9, 16'd0, ph, ft);

        // Tick lands in the FETCH cycle of a one-unit deadline
        align(13);
        run_task(8'h08, 16'd1, 16'd4, ph, ft);
        check("t5_rd_phase", ph, 14);
        check("t5_fetch_tick", ft, 1);

        for (int i = 0; i < 4; i++) begin
            run_task(8'(8'h10 + i), 16'($urandom_range(1, 6)), 16'($urandom_range(0, 6)), ph, ft);
        end

        // Queue-reported failures
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            q_fail = 1'b1;
            q_fail_data = {8'(i), 33'($urandom)};
            @(posedge clk); #1;
            q_fail = 1'b0;
            @(negedge clk);
            check("t6_fail_cnt", fail_cnt, i);
        end

        // Reset while a task runs: dropped without a report
        tb_q.push_back({8'h09, 16'd20, 16'd10, 1'b0});
        n_pops++;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 100);
        check("rst_mid_busy", busy, 1);
        repeat (20) @(negedge clk);
        check("rst_mid_running", {busy, run_id}, {1'b1, 8'h09});
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outs", {q_rd, q_subtract, q_repair, busy, done, miss}, 0);
        check("rst_mid_ids", {run_id, done_id, miss_id}, 0);
        check("rst_mid_fail_cnt", fail_cnt, 0);
        r0 = evt_cnt;
        repeat (200) @(negedge clk);
        check("rst_no_evt", evt_cnt - r0, 0);

        // Fail counter saturation
        @(posedge clk); #1 q_fail = 1'b1;
        repeat (65534) @(posedge clk);
        #1 q_fail = 1'b0;
        @(negedge clk);
        check("sat_fffe", fail_cnt, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 q_fail = 1'b1;
            @(posedge clk); #1 q_fail = 1'b0;
            @(negedge clk);
            check("sat_ffff", fail_cnt, 16'hFFFF);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("rd_total", rd_cnt, n_pops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_task_dispatcher
`default_nettype wire
